// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Holds the controller state enum, line/word geometry and processor-address
// field positions used by dcache_wb_dm and dcache_line_array.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } cache_state_e;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned MEM_ADDR_W     = 28;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned PROC_ADDR_W    = 30;

  // Processor word-address fields: [1:0] offset, then index, then tag.
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned INDEX_LSB  = OFFSET_W;

  function automatic logic [OFFSET_W-1:0] word_offset(input logic [PROC_ADDR_W-1:0] addr);
    return addr[OFFSET_LSB +: OFFSET_W];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears everything)
//   rd_idx              combinational read port index
//   rd_valid/rd_dirty/rd_tag/rd_line  state of the indexed line
//   wr_en/wr_idx/wr_word/wr_data      single-word store; marks the line dirty
//   fill_en/fill_idx/fill_tag/fill_line  full-line refill; valid=1, dirty=0
//   clean_en/clean_idx  clears dirty after a write-back
module dcache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                clean_en,
  input  logic [INDEX_W-1:0]  clean_idx
);

  localparam int unsigned NumLines = 2 ** INDEX_W;

  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [LINE_W-1:0]   data_q [NumLines];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NumLines; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // The controller never asserts more than one of these in a cycle.
      if (wr_en) begin
        data_q[wr_idx][WORD_W*wr_word +: WORD_W] <= wr_data;
        dirty_q[wr_idx] <= 1'b1;
      end
      if (fill_en) begin
        data_q[fill_idx]  <= fill_line;
        tag_q[fill_idx]   <= fill_tag;
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
      if (clean_en) begin
        dirty_q[clean_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_dirty = dirty_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_line  = data_q[rd_idx];
  end

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache.
// Processor side: proc_read/proc_write/proc_addr/proc_wdata in, proc_stall and
// proc_rdata out. Hits complete combinationally in the same cycle.
// Memory side: line-wide mem_read/mem_write/mem_addr/mem_wdata out,
// mem_rdata/mem_ready in. Misses write back a dirty victim, then refill; the
// processor keeps its request stable and the retried access hits.
module dcache_wb_dm
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_read,
  input  logic                   proc_write,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic                   proc_stall,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready
);

  cache_state_e state_q, state_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic [OFFSET_W-1:0] word_off;
  logic                req;
  logic                hit;

  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [LINE_W-1:0]   line_data;

  logic wr_en;
  logic fill_en;
  logic clean_en;

  assign idx      = proc_addr[INDEX_LSB +: INDEX_W];
  assign req_tag  = proc_addr[PROC_ADDR_W-1 -: TAG_W];
  assign word_off = word_offset(proc_addr);
  assign req      = proc_read | proc_write;
  assign hit      = line_valid && (line_tag == req_tag);

  dcache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .wr_en     (wr_en),
    .wr_idx    (idx),
    .wr_word   (word_off),
    .wr_data   (proc_wdata),
    .fill_en   (fill_en),
    .fill_idx  (idx),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata),
    .clean_en  (clean_en),
    .clean_idx (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    clean_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            // proc_write wins when both strobes are high.
            wr_en = proc_write;
          end else begin
            proc_stall = 1'b1;
            state_d    = (line_valid && line_dirty) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {line_tag, idx};
        mem_wdata  = line_data;
        if (mem_ready) begin
          clean_en = 1'b1;
          state_d  = StAllocate;
        end
      end
      StAllocate: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, idx};
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        proc_stall = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // Zero unless a load is completing, so idle/reset output is clean.
  always_comb begin
    proc_rdata = '0;
    if (state_q == StIdle && proc_read && hit) begin
      proc_rdata = line_data[WORD_W*word_off +: WORD_W];
    end
  end

endmodule

// File: doc/dcache_wb_dm.md
# dcache_wb_dm

Direct-mapped, write-back, write-allocate data cache that serves as the responder on the processor's D-cache interface and as the initiator on a line-wide main-memory interface. Hits complete in the same cycle with `proc_stall` low. Misses hold `proc_stall` high while a finite-state machine (FSM) writes back a dirty victim and then refills the line. The block sits between the pipeline's MEM stage and the memory model/arbiter.

## Interface
- `INDEX_W`, default 3: index bits. The cache has 2^INDEX_W lines of 4 × 32-bit words.
- `TAG_W`, default 25: tag bits. TAG_W = 28 − INDEX_W.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low; clock is `clk`.
- `proc_read`  in  1  load request.
- `proc_write`  in  1  store request.
- `proc_addr`  in  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- `proc_wdata`  in  32  store data.
- `proc_stall`  out  1  request not yet complete.
- `proc_rdata`  out  32  load data, valid when `proc_read` is high and `proc_stall` is low.
- `mem_read`  out  1  line refill request.
- `mem_write`  out  1  line write-back request.
- `mem_addr`  out  28  line address, equal to {tag, index}.
- `mem_wdata`  out  128  victim line; word 0 is in [31:0].
- `mem_rdata`  in  128  refill line, valid when `mem_ready` is high.
- `mem_ready`  in  1  one-cycle completion pulse for the current mem request.

## Operation
- Per line, the block stores `valid`, `dirty`, `tag` and 4 data words.
- Hit: `valid[idx] && tag[idx]==proc_addr tag`, evaluated combinationally.
- Request present: `proc_read || proc_write`.
  - When both are high, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Read hit: `proc_rdata` = the selected word; `proc_stall` = 0.
  - Write hit: `proc_stall` = 0. At the clock edge the addressed word takes `proc_wdata` and `dirty` is set.
  - Miss on a dirty victim: `proc_stall` = 1; next state WRITEBACK.
  - Miss on a clean or invalid victim: `proc_stall` = 1; next state ALLOCATE.
  - No request: `proc_stall` = 0; the state stays IDLE.
- WRITEBACK:
  - Drives `mem_write`=1, `mem_addr`={victim tag, idx} and `mem_wdata`=victim line.
  - On `mem_ready`: clear `dirty`; next state ALLOCATE.
- ALLOCATE:
  - Drives `mem_read`=1 and `mem_addr`={request tag, idx}.
  - On `mem_ready`: data ← `mem_rdata`, tag ← request tag, `valid`=1, `dirty`=0; next state IDLE.
  - The retried access then hits. A store is merged in the IDLE hit cycle, not during the refill.
- `proc_stall` is 1 in every cycle the state is not IDLE.
- The processor holds `proc_*` stable while `proc_stall` is high. The block does not latch the request; it re-derives index and tag from `proc_addr`.
- `mem_read` and `mem_write` are never high together.
- `mem_ready` is ignored in IDLE.
- `mem_addr` and `mem_wdata` are 0 in IDLE.

## Timing
- Reset values:
  - State IDLE; all `valid`, `dirty`, tags and data cleared to 0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `proc_rdata`=0.
  - `proc_stall`=0 when no request is present.
- Hit: 0 added cycles.
- Clean miss with memory latency L (`mem_ready` in the L-th cycle of the request): `proc_stall` is high for 1+L cycles, then low for the hit cycle.
- Dirty miss: `proc_stall` is high for 1+L_wb+L_rd cycles.
- Mem request outputs are decoded from the registered state and are stable until `mem_ready`. The memory side samples them on any cycle.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and `mem_read`/`mem_write` drop asynchronously. A partially written-back line is lost (accepted behaviour).
- The index wraps naturally: addresses differing only in tag map to the same line and evict each other.

## Structure
- `cache_pkg` holds:
  - the state enum (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2);
  - `LINE_W`=128, `WORDS_PER_LINE`=4, `MEM_ADDR_W`=28;
  - address-field slice helper constants.
- Sub-module `dcache_line_array` holds the valid/dirty/tag/data storage with async reset. It provides:
  - a combinational read port;
  - a word-write port;
  - a full-line fill port.
- The top level contains the FSM, hit logic and output muxing.

## Test plan
The memory model has fixed latency L=4, and `INDEX_W` is 3 throughout.

- Cold read: reset, then read `proc_addr`=0x000_0010 → `proc_stall`=1 for 5 cycles. `mem_read`=1 with `mem_addr`=0x000_0004 in cycles 1–4. Cycle 5: `proc_stall`=0 and `proc_rdata` = word 0 of the model line.
- Write hit then read: after the cold read, write 0xDEADBEEF to 0x000_0011 → no stall. The next read of 0x000_0011 returns 0xDEADBEEF with no stall and no mem activity.
- Dirty eviction: read 0x000_0111 (same index 4, different tag) → WRITEBACK with `mem_addr`=0x000_0004 and `mem_wdata`[63:32]=0xDEADBEEF. This is followed by ALLOCATE with `mem_addr`=0x000_0044. Stall lasts 9 cycles.
- Write miss allocate: store to a cold line → refill first (stall 5). The store merges in the hit cycle, and the line is dirty afterwards.
- Reset mid-ALLOCATE: pull `rst_n` low in the 2nd ALLOCATE cycle → `mem_read` drops the same cycle. A later read of that address misses again.
- Simultaneous read and write high to the same address → handled as a write; `proc_stall` behaviour is the same as for a write.
